// File: rtl/load_aligner.sv
// Load data aligner: selects, extends and merges a raw memory word into the
// destination register value for byte/half/word/LWL/LWR/LWU/LD loads.
module load_aligner #(
    parameter int DATA_W     = 32,
    parameter bit BIG_ENDIAN = 1'b0,
    parameter int TAG_W      = 5,
    localparam int AW        = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [AW-1:0]     in_addr,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [DATA_W-1:0] in_old,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_misalign
);

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_LWL = 3'd5;
    localparam logic [2:0] OP_LWR = 3'd6;
    localparam logic [2:0] OP_LD  = 3'd7;

    localparam logic [DATA_W-1:0] LO_WORD = DATA_W'(32'hFFFF_FFFF);

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high; valid and its payload hold until that edge, ready may depend
    // combinationally on downstream ready.
    logic [AW-1:0] b;
    logic [2:0]    b3;
    logic          lane;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic [31:0]   sel_word;
    logic          in_ld;
    logic          in_mis;
    logic          s2_free;

    logic              s1_valid;
    logic [2:0]        s1_op;
    logic [1:0]        s1_k;
    logic              s1_mis;
    logic              s1_ld;
    logic [7:0]        s1_byte;
    logic [15:0]       s1_half;
    logic [31:0]       s1_word;
    logic [DATA_W-1:0] s1_mem;
    logic [DATA_W-1:0] s1_old;
    logic [TAG_W-1:0]  s1_tag;

    logic [31:0]       lwl_word;
    logic [31:0]       lwr_word;
    logic [DATA_W-1:0] res;

    assign b        = in_addr ^ {AW{BIG_ENDIAN}};
    assign b3       = 3'(b);
    assign lane     = (DATA_W == 64) ? b3[2] : 1'b0;
    assign sel_byte = 8'(in_mem >> {b, 3'b000});
    assign sel_half = 16'(in_mem >> {b[AW-1:1], 4'b0000});
    assign sel_word = 32'(in_mem >> {lane, 5'b00000});
    assign in_ld    = (DATA_W == 64) && (in_op == OP_LD) && (in_addr == '0);

    always_comb begin
        in_mis = 1'b0;
        case (in_op)
            OP_LH, OP_LHU: in_mis = in_addr[0];
            OP_LW, OP_LD:  in_mis = (in_addr[1:0] != 2'b00);
            default:       in_mis = 1'b0;
        endcase
    end

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !rst && (!s1_valid || s2_free);

    // LWL shifts the low k+1 memory bytes to the top; LWR shifts the high
    // 4-k bytes to the bottom; the untouched bytes come from the old value.
    always_comb begin
        lwl_word = (s1_word << {~s1_k, 3'b000})
                 | (s1_old[31:0] & (32'h00FF_FFFF >> {s1_k, 3'b000}));
        lwr_word = (s1_word >> {s1_k, 3'b000})
                 | (s1_old[31:0] & ~(32'hFFFF_FFFF >> {s1_k, 3'b000}));
        res = '0;
        case (s1_op)
            OP_LB:   res = DATA_W'($signed(s1_byte));
            OP_LBU:  res = DATA_W'(s1_byte);
            OP_LH:   res = DATA_W'($signed(s1_half));
            OP_LHU:  res = DATA_W'(s1_half);
            OP_LW:   res = DATA_W'($signed(s1_word));
            OP_LWL:  res = DATA_W'($signed(lwl_word));
            OP_LWR:  res = (DATA_W == 64 && s1_k != 2'b00)
                         ? ((s1_old & ~LO_WORD) | DATA_W'(lwr_word))
                         : DATA_W'($signed(lwr_word));
            OP_LD:   res = s1_ld ? s1_mem : DATA_W'(s1_word);
            default: res = '0;
        endcase
        if (s1_mis) begin
            res = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_tag      <= '0;
            out_misalign <= 1'b0;
        end else if (flush) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (s2_free) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data     <= res;
                    out_tag      <= s1_tag;
                    out_misalign <= s1_mis;
                end
            end
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_op   <= in_op;
                    s1_k    <= b3[1:0];
                    s1_mis  <= in_mis;
                    s1_ld   <= in_ld;
                    s1_byte <= sel_byte;
                    s1_half <= sel_half;
                    s1_word <= sel_word;
                    s1_mem  <= in_mem;
                    s1_old  <= in_old;
                    s1_tag  <= in_tag;
                end
            end
        end
    end

endmodule

// File: doc/load_aligner.md
LOAD_ALIGNER -- requirements
Module: load_aligner

Interface
REQ-001 Parameter DATA_W, default 32, load data path width; legal values 32 and 64.
REQ-002 Parameter BIG_ENDIAN, default 0; 1 selects big-endian byte numbering.
REQ-003 Parameter TAG_W, default 5, width of the destination-register tag.
REQ-004 Localparam AW = log2(DATA_W/8).
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 flush  in  1  discards all in-flight entries.
REQ-008 in_valid  in  1  request valid.
REQ-009 in_ready  out  1  request accepted when in_valid & in_ready.
REQ-010 in_op  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 7 LWU/LD.
REQ-011 in_addr  in  AW  low address bits of the load.
REQ-012 in_mem  in  DATA_W  raw aligned memory word.
REQ-013 in_old  in  DATA_W  current destination register value, used by LWL/LWR.
REQ-014 in_tag  in  TAG_W  destination tag, passed through unchanged.
REQ-015 out_valid  out  1  result valid.
REQ-016 out_ready  in  1  downstream accepts result when out_valid & out_ready.
REQ-017 out_data  out  DATA_W  aligned and extended result.
REQ-018 out_tag  out  TAG_W  tag of the result.
REQ-019 out_misalign  out  1  address-error flag for the result.

Function
REQ-020 b = in_addr XOR (BIG_ENDIAN ? all-ones : 0); all lane selection uses b.
REQ-021 Two registered stages. S1 captures the request and the selected bytes. S2 performs extension and merge and drives the out_* ports. Latency is exactly 2 cycles with no stall.
REQ-022 Each stage holds a valid bit. A stage advances when the stage after it is empty or being consumed.
REQ-023 in_ready = !S1.valid | S2 advancing. Full throughput is 1 result per cycle.
REQ-024 out_* ports stay stable while out_valid & !out_ready.
REQ-025 LB/LBU return byte b, sign- or zero-extended to DATA_W.
REQ-026 LH/LHU return halfword b[AW-1:1], sign- or zero-extended.
REQ-027 LW and LWL/LWR operate on word lane w: w = b[2] when DATA_W=64, otherwise the whole word. LW sign-extends to DATA_W.
REQ-028 LWL, with k = b[1:0]: result word bytes 3..3-k = mem word bytes k..0; lower 3-k bytes come from in_old. When DATA_W=64, the result is sign-extended from bit 31.
REQ-029 LWR, with k = b[1:0]: result word bytes 3-k..0 = mem word bytes 3..k; upper k bytes come from in_old word. When DATA_W=64, upper 32 bits come from in_old unless k=0, in which case the result is sign-extended.
REQ-030 Op 7 depends on DATA_W.
- DATA_W=32: identical to LW.
- DATA_W=64 with b[2] selected by addr: LWU when in_addr[2:0] is not 0 mod 8 lane-aligned-doubleword? No — decided rule: op 7 = LD if in_addr==0, else LWU of lane w, zero-extended.
REQ-031 out_misalign=1 and out_data=0 for:
- LH/LHU with addr[0]=1;
- LW/LWU with addr[1:0] != 0.
LB/LBU/LWL/LWR never set the flag.
REQ-032 flush clears both valid bits at the edge; a request presented in the flush cycle is dropped. in_ready is 1 in the following cycle.
REQ-033 Simultaneous flush and out_ready: the flush wins and no handshake is counted downstream.

Reset
REQ-034 On rst: both valid bits are 0; out_valid=0; out_data=0; out_tag=0; out_misalign=0.
REQ-035 in_ready=0 during the rst cycle and 1 in the first cycle after rst is released.
REQ-036 rst asserted mid-operation discards all entries identically to flush; no partial result is ever emitted.

Verification
REQ-037 DATA_W=32, LE, LB, addr=3, mem=0x80FF_1234 -> 2 cycles later out_data=0xFFFF_FF80, misalign=0.
REQ-038 DATA_W=32, LE, LWL, addr=1, mem=0xAABB_CCDD, old=0x1122_3344 -> out_data=0xCCDD_3344. LWR addr=1 with the same operands -> out_data=0x11AA_BBCC.
REQ-039 BIG_ENDIAN=1, LHU, addr=0, mem=0x8001_7FFE -> out_data=0x0000_8001.
REQ-040 DATA_W=64, LW, addr=4, mem=0x8000_0001_0000_0002 -> out_data=0xFFFF_FFFF_8000_0001. LH addr=3 -> misalign=1, out_data=0.
REQ-041 Back-to-back stream of 4 requests with out_ready low for 3 cycles -> in_ready falls after 2 accepts; all 4 results emerge in order with stable data during the stall.
REQ-042 flush with 2 entries in flight -> out_valid=0 next cycle; no stale tag appears afterwards.
